// File: rtl/led_pwm_decoder_if.sv
// LED bus and decoded-result bundle for led_pwm_decoder.
// master: whoever drives the LED pins and consumes results; slave: the decoder.
interface led_pwm_decoder_if;
   logic [2:0] led_in;
   logic [7:0] red_level;
   logic [7:0] green_level;
   logic [7:0] blue_level;
   logic [2:0] dominant;
   logic       changed;
   logic       out_valid;

   modport master (
      output led_in,
      input  red_level, green_level, blue_level, dominant, changed, out_valid
   );

   modport slave (
      input  led_in,
      output red_level, green_level, blue_level, dominant, changed, out_valid
   );
endinterface

// File: rtl/led_pwm_decoder.sv
// led_pwm_decoder: samples an active-low time-multiplexed RGB LED bus and
// publishes per-channel on-sample counts once per WINDOW_TICKS samples.
// Optional macro LED_PWM_DECODER_SYNC_EN puts a 2-flop synchronizer on led_in.
// led_in bit mapping: bit2=red, bit1=blue, bit0=green (0 = lit).
module led_pwm_decoder #(
   parameter int WINDOW_TICKS = 255,
   parameter int SAMPLE_DIV   = 1
) (
   input  logic             clk,
   input  logic             rst,
   led_pwm_decoder_if.slave bus
);

   // internal channel order: 0=red, 1=green, 2=blue
   localparam int NUM_CH = 3;

   logic [2:0]              led_s;
   logic [15:0]             div_cnt;
   logic                    sample_en;
   logic [7:0]              win_cnt;
   logic                    win_last;
   logic [NUM_CH-1:0]       ch_on;
   logic [NUM_CH-1:0][7:0]  acc;
   logic [NUM_CH-1:0][7:0]  cnt_new;
   logic [NUM_CH-1:0][7:0]  level_q;
   logic [2:0]              dom_new;
   logic [2:0]              dom_q;
   logic                    changed_q;
   logic                    valid_q;

`ifdef LED_PWM_DECODER_SYNC_EN
   logic [2:0] sync_q1, sync_q2;

   // two-flop synchronizer; resets to all-off so no phantom samples leak in
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 3'b111;
         sync_q2 <= 3'b111;
      end else begin
         sync_q1 <= bus.led_in;
         sync_q2 <= sync_q1;
      end
   end

   assign led_s = sync_q2;
`else
   assign led_s = bus.led_in;
`endif

   assign sample_en = (div_cnt == 16'(SAMPLE_DIV - 1));
   assign win_last  = sample_en && (win_cnt == 8'(WINDOW_TICKS - 1));
   assign ch_on     = {~led_s[1], ~led_s[0], ~led_s[2]};

   // sample-enable divider, wraps on the enable cycle
   always_ff @(posedge clk) begin
      if (rst)            div_cnt <= '0;
      else if (sample_en) div_cnt <= '0;
      else                div_cnt <= div_cnt + 16'd1;
   end

   // window position; clears on the final sample so windows abut with no gap
   always_ff @(posedge clk) begin
      if (rst)            win_cnt <= '0;
      else if (win_last)  win_cnt <= '0;
      else if (sample_en) win_cnt <= win_cnt + 8'd1;
   end

   // per-channel accumulators; cnt_new folds in the current sample so the
   // final sample of a window lands in the published count
   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      assign cnt_new[ch] = acc[ch] + 8'(ch_on[ch]);

      // count lit samples, restart at window end
      always_ff @(posedge clk) begin
         if (rst)            acc[ch] <= '0;
         else if (win_last)  acc[ch] <= '0;
         else if (sample_en) acc[ch] <= cnt_new[ch];
      end
   end

   // strongest channel of the window being closed; ties go red > green > blue
   always_comb begin
      dom_new = 3'b111;
      if (cnt_new[0] != 8'd0 && cnt_new[0] >= cnt_new[1] && cnt_new[0] >= cnt_new[2])
         dom_new = 3'b011;
      else if (cnt_new[1] != 8'd0 && cnt_new[1] >= cnt_new[2])
         dom_new = 3'b110;
      else if (cnt_new[2] != 8'd0)
         dom_new = 3'b101;
   end

   // publish registers: results and strobe update together on the final sample
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q   <= '0;
         dom_q     <= 3'b111;
         changed_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= win_last;
         if (win_last) begin
            level_q   <= cnt_new;
            dom_q     <= dom_new;
            changed_q <= (cnt_new != level_q);
         end
      end
   end

   assign bus.red_level   = level_q[0];
   assign bus.green_level = level_q[1];
   assign bus.blue_level  = level_q[2];
   assign bus.dominant    = dom_q;
   assign bus.changed     = changed_q;
   assign bus.out_valid   = valid_q;

endmodule

// File: tb/tb_led_pwm_decoder.sv
// Directed bench for led_pwm_decoder: default build, a 254-sample window
// instance for the exact-tie case, and a SAMPLE_DIV=4 instance.
module tb_led_pwm_decoder;

`ifdef LED_PWM_DECODER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] led_a = 3'b111;
   logic [2:0] led_e = 3'b111;
   logic [2:0] led_d = 3'b111;
   int         total = 0;
   int         bad   = 0;

   led_pwm_decoder_if bus_a ();
   led_pwm_decoder_if bus_e ();
   led_pwm_decoder_if bus_d ();

   assign bus_a.led_in = led_a;
   assign bus_e.led_in = led_e;
   assign bus_d.led_in = led_d;

   led_pwm_decoder dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   led_pwm_decoder #(.WINDOW_TICKS(254)) dut_e (.clk(clk), .rst(rst), .bus(bus_e));
   led_pwm_decoder #(.SAMPLE_DIV(4))     dut_d (.clk(clk), .rst(rst), .bus(bus_d));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {red, green, blue, dominant, changed, out_valid}
   function automatic logic [28:0] obs(input int sel);
      case (sel)
         1:       return {bus_e.red_level, bus_e.green_level, bus_e.blue_level,
                          bus_e.dominant, bus_e.changed, bus_e.out_valid};
         2:       return {bus_d.red_level, bus_d.green_level, bus_d.blue_level,
                          bus_d.dominant, bus_d.changed, bus_d.out_valid};
         default: return {bus_a.red_level, bus_a.green_level, bus_a.blue_level,
                          bus_a.dominant, bus_a.changed, bus_a.out_valid};
      endcase
   endfunction

   // 0 off, 1 red, 2 red then magenta at sample 100, 3 green/red alternating
   function automatic logic [2:0] pat(input int kind, input int k);
      case (kind)
         1:       return 3'b011;
         2:       return (k < 100) ? 3'b011 : 3'b001;
         3:       return (k % 2 == 0) ? 3'b110 : 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   // One full window on instance sel; pins lead samples by LAT cycles, so the
   // tail of the window already carries the next window's pattern.
   task automatic run_window(input int sel, input int wlen, input int cur,
                             input int nxt, output int early);
      logic [2:0] v;
      int         k;
      early = 0;
      for (int t = 0; t < wlen; t++) begin
         k = t + LAT;
         v = (k < wlen) ? pat(cur, k) : pat(nxt, k - wlen);
         case (sel)
            1:       led_e = v;
            2:       led_d = v;
            default: led_a = v;
         endcase
         tick();
         if (t < wlen - 1 && obs(sel)[0]) early++;
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      led_a = 3'b111;
      led_e = 3'b111;
      led_d = 3'b111;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [28:0] exp_v;
      do_reset();
      exp_v = {8'd0, 8'd0, 8'd0, 3'b111, 1'b0, 1'b0};
      total++;
      if (obs(0) !== exp_v) begin
         bad++; $display("FAIL reset_state got=%h exp=%h", obs(0), exp_v);
      end
   endtask

   task automatic test_idle();
      int          early;
      logic [28:0] exp_v;
      run_window(0, 255, 0, 1, early);
      exp_v = {8'd0, 8'd0, 8'd0, 3'b111, 1'b0, 1'b1};
      total++;
      if (early !== 0) begin bad++; $display("FAIL idle_early_valid got=%0d exp=0", early); end
      total++;
      if (obs(0) !== exp_v) begin bad++; $display("FAIL idle_window got=%h exp=%h", obs(0), exp_v); end
   endtask

   task automatic test_red_hold();
      int          early;
      logic [28:0] exp_v;
      run_window(0, 255, 1, 1, early);
      exp_v = {8'd255, 8'd0, 8'd0, 3'b011, 1'b1, 1'b1};
      total++;
      if (early !== 0) begin bad++; $display("FAIL red1_early_valid got=%0d exp=0", early); end
      total++;
      if (obs(0) !== exp_v) begin bad++; $display("FAIL red_first got=%h exp=%h", obs(0), exp_v); end
      run_window(0, 255, 1, 2, early);
      exp_v = {8'd255, 8'd0, 8'd0, 3'b011, 1'b0, 1'b1};
      total++;
      if (early !== 0) begin bad++; $display("FAIL red2_early_valid got=%0d exp=0", early); end
      total++;
      if (obs(0) !== exp_v) begin bad++; $display("FAIL red_second got=%h exp=%h", obs(0), exp_v); end
   endtask

   task automatic test_magenta();
      int          early;
      logic [28:0] exp_v;
      run_window(0, 255, 2, 3, early);
      exp_v = {8'd255, 8'd0, 8'd155, 3'b011, 1'b1, 1'b1};
      total++;
      if (obs(0) !== exp_v) begin bad++; $display("FAIL magenta got=%h exp=%h", obs(0), exp_v); end
   endtask

   task automatic test_alternate();
      int          early;
      logic [28:0] exp_v;
      run_window(0, 255, 3, 0, early);
      exp_v = {8'd127, 8'd128, 8'd0, 3'b110, 1'b1, 1'b1};
      total++;
      if (obs(0) !== exp_v) begin bad++; $display("FAIL alternate got=%h exp=%h", obs(0), exp_v); end
   endtask

   task automatic test_reset_mid();
      int          early;
      logic [28:0] exp_v;
      led_a = 3'b111;
      repeat (100) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_v = {8'd0, 8'd0, 8'd0, 3'b111, 1'b0, 1'b0};
      total++;
      if (obs(0) !== exp_v) begin bad++; $display("FAIL mid_reset_clear got=%h exp=%h", obs(0), exp_v); end
      run_window(0, 255, 0, 0, early);
      total++;
      if (early !== 0) begin bad++; $display("FAIL mid_reset_early got=%0d exp=0", early); end
      exp_v = {8'd0, 8'd0, 8'd0, 3'b111, 1'b0, 1'b1};
      total++;
      if (obs(0) !== exp_v) begin bad++; $display("FAIL mid_reset_window got=%h exp=%h", obs(0), exp_v); end
   endtask

   task automatic test_reset_final();
      int early;
      int vcnt;
      vcnt = 0;
      for (int t = 0; t < 254; t++) begin
         tick();
         if (obs(0)[0]) vcnt++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if (obs(0)[0]) vcnt++;
      total++;
      if (vcnt !== 0) begin bad++; $display("FAIL reset_on_final got=%0d exp=0", vcnt); end
      run_window(0, 255, 0, 0, early);
      total++;
      if ({early[7:0], obs(0)[0]} !== {8'd0, 1'b1}) begin
         bad++; $display("FAIL after_final_reset got=%0d/%b exp=0/1", early, obs(0)[0]);
      end
   endtask

   task automatic test_equal_split();
      int          early;
      logic [28:0] exp_v;
      do_reset();
      run_window(1, 254, 0, 3, early);
      exp_v = {8'd0, 8'd0, 8'd0, 3'b111, 1'b0, 1'b1};
      total++;
      if (obs(1) !== exp_v) begin bad++; $display("FAIL split_idle got=%h exp=%h", obs(1), exp_v); end
      run_window(1, 254, 3, 0, early);
      exp_v = {8'd127, 8'd127, 8'd0, 3'b011, 1'b1, 1'b1};
      total++;
      if (early !== 0) begin bad++; $display("FAIL split_early got=%0d exp=0", early); end
      total++;
      if (obs(1) !== exp_v) begin bad++; $display("FAIL split_tie got=%h exp=%h", obs(1), exp_v); end
   endtask

   task automatic test_sample_div();
      int          vcnt;
      logic [28:0] exp_v;
      do_reset();
      led_d = 3'b101;
      vcnt  = 0;
      for (int t = 0; t < 1019; t++) begin
         tick();
         if (obs(2)[0]) vcnt++;
      end
      total++;
      if (vcnt !== 0) begin bad++; $display("FAIL div_early got=%0d exp=0", vcnt); end
      tick();
      exp_v = {8'd0, 8'd0, 8'd255, 3'b101, 1'b1, 1'b1};
      total++;
      if (obs(2) !== exp_v) begin bad++; $display("FAIL div_first got=%h exp=%h", obs(2), exp_v); end
      vcnt = 0;
      for (int t = 0; t < 1019; t++) begin
         tick();
         if (obs(2)[0]) vcnt++;
      end
      total++;
      if (vcnt !== 0) begin bad++; $display("FAIL div_gap got=%0d exp=0", vcnt); end
      tick();
      exp_v = {8'd0, 8'd0, 8'd255, 3'b101, 1'b0, 1'b1};
      total++;
      if (obs(2) !== exp_v) begin bad++; $display("FAIL div_second got=%h exp=%h", obs(2), exp_v); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_red_hold();
      test_magenta();
      test_alternate();
      test_reset_mid();
      test_reset_final();
      test_equal_split();
      test_sample_div();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
